// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: one-time loader for the conv/FC weight buffer.
// The loader takes 32-bit host words, unpacks each one into BW-bit lanes
// (lane 0 first) and writes one byte per cycle into the buffer. After the
// last byte it waits for the buffer to report full, then raises done.
// If the buffer reports full too early, or never reports full, it raises err.
module weight_load_ctrl #(
    parameter int  BW     = 8,
    parameter int  SIZE   = 3220,
    parameter int  WORD_W = 32,
    localparam int LANES  = WORD_W / BW,
    localparam int CW     = $clog2(SIZE + 1),
    localparam int IW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 user_reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_valid,
    input  logic [WORD_W-1:0]    i_word,
    output logic                 o_ready,
    output logic                 o_buf_clr,
    output logic                 o_buf_ce,
    output logic                 o_buf_we,
    output logic signed [BW-1:0] o_buf_data,
    input  logic                 i_buf_full,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_irq,
    output logic [CW-1:0]        o_cnt
);

    localparam int FW = CW + IW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                   state;
    logic [LANES-1:0][BW-1:0] hold_p0;
    logic                     vld_p0;
    logic [IW-1:0]            idx_p0;
    logic [CW-1:0]            cnt_q;
    logic [1:0]               wait_cnt;
    logic                     irq_q;

    logic                     last_lane;
    logic [FW-1:0]            fill_lvl;
    logic                     wr_en;
    logic                     ready;
    logic                     accept;

    // Write qualification and host handshake. A new word is taken only while
    // the bytes already committed (written plus still held) leave room below
    // SIZE, so surplus words stay with the host. During CLEAR the register is
    // known empty, which gives the two-cycle start-to-first-write latency.
    always_comb begin
        last_lane = (idx_p0 == IW'(LANES - 1));
        fill_lvl  = FW'(cnt_q);
        if (vld_p0) begin
            fill_lvl = fill_lvl + FW'(LANES) - FW'(idx_p0);
        end
        wr_en  = (state == S_LOAD) && vld_p0 && !i_abort && !i_buf_full
                 && (cnt_q != CW'(SIZE));
        ready  = !i_abort
                 && ((state == S_CLEAR)
                     || ((state == S_LOAD) && !i_buf_full
                         && (!vld_p0 || (wr_en && last_lane))
                         && (fill_lvl < FW'(SIZE))));
        accept = i_valid && ready;
    end

    // Control FSM, holding register and byte counter.
    always_ff @(posedge clk) begin
        if (user_reset) begin
            state    <= S_IDLE;
            hold_p0  <= '0;
            vld_p0   <= 1'b0;
            idx_p0   <= '0;
            cnt_q    <= '0;
            wait_cnt <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (i_abort) begin
                // Buffer contents and the byte count are left for debug.
                state    <= S_IDLE;
                vld_p0   <= 1'b0;
                idx_p0   <= '0;
                wait_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) state <= S_CLEAR;
                    end
                    S_CLEAR: begin
                        cnt_q  <= '0;
                        idx_p0 <= '0;
                        vld_p0 <= accept;
                        if (accept) hold_p0 <= i_word[LANES*BW-1:0];
                        state  <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (i_buf_full) begin
                            // Buffer filled before every byte was written.
                            state  <= S_ERR;
                            irq_q  <= 1'b1;
                            vld_p0 <= 1'b0;
                            idx_p0 <= '0;
                        end else if (wr_en) begin
                            cnt_q <= cnt_q + CW'(1);
                            if (cnt_q == CW'(SIZE - 1)) begin
                                // Remaining lanes of a partial final word are dropped.
                                state    <= S_WAIT;
                                wait_cnt <= '0;
                                vld_p0   <= 1'b0;
                                idx_p0   <= '0;
                            end else if (last_lane) begin
                                idx_p0 <= '0;
                                vld_p0 <= accept;
                                if (accept) hold_p0 <= i_word[LANES*BW-1:0];
                            end else begin
                                idx_p0 <= idx_p0 + IW'(1);
                            end
                        end else if (accept) begin
                            hold_p0 <= i_word[LANES*BW-1:0];
                            vld_p0  <= 1'b1;
                            idx_p0  <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (i_buf_full) begin
                            state <= S_DONE;
                            irq_q <= 1'b1;
                        end else if (wait_cnt == 2'd3) begin
                            state <= S_ERR;
                            irq_q <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 2'd1;
                        end
                    end
                    S_DONE, S_ERR: begin
                        if (i_start) state <= S_CLEAR;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Buffer port and status decode.
    always_comb begin
        o_ready    = ready;
        o_buf_clr  = (state == S_CLEAR) && !i_abort;
        o_buf_ce   = (state == S_CLEAR) || (state == S_LOAD);
        o_buf_we   = wr_en;
        o_buf_data = $signed(hold_p0[idx_p0]);
        o_busy     = (state == S_CLEAR) || (state == S_LOAD) || (state == S_WAIT);
        o_done     = (state == S_DONE);
        o_err      = (state == S_ERR);
        o_irq      = irq_q;
        o_cnt      = cnt_q;
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: a full-size loader (SIZE=3220) and a small one
// (SIZE=6) sharing clock and reset. Bytes of every accepted host word are
// queued in a scoreboard and popped as the loader writes them.
module tb_weight_load_ctrl;

    localparam int SIZE_A = 3220;
    localparam int SIZE_B = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_start, a_abort, a_valid, a_full;
    logic [31:0] a_word;
    logic        a_ready, a_clr, a_ce, a_we, a_busy, a_done, a_err, a_irq;
    logic [7:0]  a_data;
    logic [11:0] a_cnt;

    logic        b_start, b_abort, b_valid, b_full;
    logic [31:0] b_word;
    logic        b_ready, b_clr, b_ce, b_we, b_busy, b_done, b_err, b_irq;
    logic [7:0]  b_data;
    logic [2:0]  b_cnt;

    weight_load_ctrl #(.BW(8), .SIZE(SIZE_A), .WORD_W(32)) dut_a (
        .clk(clk), .user_reset(rst), .i_start(a_start), .i_abort(a_abort),
        .i_valid(a_valid), .i_word(a_word), .o_ready(a_ready), .o_buf_clr(a_clr),
        .o_buf_ce(a_ce), .o_buf_we(a_we), .o_buf_data(a_data), .i_buf_full(a_full),
        .o_busy(a_busy), .o_done(a_done), .o_err(a_err), .o_irq(a_irq), .o_cnt(a_cnt)
    );

    weight_load_ctrl #(.BW(8), .SIZE(SIZE_B), .WORD_W(32)) dut_b (
        .clk(clk), .user_reset(rst), .i_start(b_start), .i_abort(b_abort),
        .i_valid(b_valid), .i_word(b_word), .o_ready(b_ready), .o_buf_clr(b_clr),
        .o_buf_ce(b_ce), .o_buf_we(b_we), .o_buf_data(b_data), .i_buf_full(b_full),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_irq(b_irq), .o_cnt(b_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0]     word;
        logic [3:0][7:0] e;    // e[0] is the byte expected first
        int              nwr;  // bytes of this word expected on the write port
        bit              acc;  // word expected to be accepted
    } vec_t;

    vec_t tab_a [4];
    vec_t tab_b [3];

    function automatic logic [31:0] gen_word(input int k);
        logic [31:0] w;
        if (k < 4) return tab_a[k].word;
        for (int l = 0; l < 4; l++) w[8*l +: 8] = 8'((4 * k + l) * 37 + 11);
        return w;
    endfunction

    // Scoreboard state for dut_a
    logic [7:0]  sb_q [$];
    int          pushed    = 0;
    int          wr_cnt    = 0;
    int          first_we  = -1;
    int          last_we   = -1;
    int          start_cyc = 0;
    int          cyc       = 0;
    int          irq_cnt   = 0;
    int          run_id    = 0;
    int          seen_run  = 0;
    logic [7:0]  log_a   [16];
    logic [11:0] cnt_log [16];

    // dut_a monitor: push accepted bytes, pop and compare on each write
    always @(negedge clk) begin
        logic [7:0] exp_b;
        cyc++;
        if (run_id != seen_run) begin
            seen_run = run_id;
            sb_q.delete();
            pushed   = 0;
            wr_cnt   = 0;
            first_we = -1;
        end
        if (a_start) start_cyc = cyc;
        if (a_valid && a_ready) begin
            for (int l = 0; l < 4; l++) begin
                if (pushed < SIZE_A) begin
                    sb_q.push_back(a_word[8*l +: 8]);
                    pushed++;
                end
            end
        end
        if (a_we) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL wr_without_data: write at cnt=%0d with no pending byte", a_cnt);
            end else begin
                exp_b = sb_q.pop_front();
                check("wr_data", 32'(a_data), 32'(exp_b));
            end
            check("wr_cnt_track", 32'(a_cnt), 32'(wr_cnt));
            if (wr_cnt < 16) begin
                log_a[wr_cnt]   = a_data;
                cnt_log[wr_cnt] = a_cnt;
            end
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            wr_cnt++;
        end
        if (a_irq) irq_cnt++;
    end

    // dut_b monitor: log the write port
    int         b_wr = 0;
    logic [7:0] b_log [8];
    always @(negedge clk) begin
        if (b_we) begin
            if (b_wr < 8) b_log[b_wr] = b_data;
            b_wr++;
        end
    end

    // Start dut_a, then feed words (gap_pct % idle cycles) until o_cnt reaches stop.
    task automatic stream_a(input int gap_pct, input int stop, output int words);
        int it;
        words = 0;
        @(posedge clk); #1;
        run_id++;
        a_start = 1'b1;
        a_valid = 1'b1;
        a_word  = gen_word(0);
        @(posedge clk); #1;
        a_start = 1'b0;
        it = 0;
        forever begin
            @(negedge clk);
            if (it == 0) begin
                check("clr_pulse", 32'(a_clr), 32'd1);
                check("status_cleared", 32'(a_done | a_err), 32'd0);
            end else if (it == 1) begin
                check("clr_single", 32'(a_clr), 32'd0);
            end
            if (a_valid && a_ready) words++;
            @(posedge clk); #1;
            it++;
            if (int'(a_cnt) >= stop) break;
            if (it > 20000) begin
                check("stream_timeout", 32'(a_cnt), 32'(stop));
                break;
            end
            a_valid = ($urandom_range(99) >= gap_pct);
            a_word  = gen_word(words);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int  words;
        int  irq_base;
        int  pos;
        bit  got;

        tab_a[0] = '{word: 32'h04030201, e: {8'h04, 8'h03, 8'h02, 8'h01}, nwr: 4, acc: 1'b1};
        tab_a[1] = '{word: 32'h8000FF7F, e: {8'h80, 8'h00, 8'hFF, 8'h7F}, nwr: 4, acc: 1'b1};
        tab_a[2] = '{word: 32'hDEADBEEF, e: {8'hDE, 8'hAD, 8'hBE, 8'hEF}, nwr: 4, acc: 1'b1};
        tab_a[3] = '{word: 32'h00FF0180, e: {8'h00, 8'hFF, 8'h01, 8'h80}, nwr: 4, acc: 1'b1};
        tab_b[0] = '{word: 32'h44332211, e: {8'h44, 8'h33, 8'h22, 8'h11}, nwr: 4, acc: 1'b1};
        tab_b[1] = '{word: 32'h88776655, e: {8'h88, 8'h77, 8'h66, 8'h55}, nwr: 2, acc: 1'b1};
        tab_b[2] = '{word: 32'hCCBBAA99, e: {8'hCC, 8'hBB, 8'hAA, 8'h99}, nwr: 0, acc: 1'b0};

        rst = 1'b1;
        a_start = 0; a_abort = 0; a_valid = 0; a_full = 0; a_word = '0;
        b_start = 0; b_abort = 0; b_valid = 0; b_full = 0; b_word = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(a_ready), 0);
        check("rst_busy",  32'(a_busy),  0);
        check("rst_done",  32'(a_done),  0);
        check("rst_err",   32'(a_err),   0);
        check("rst_irq",   32'(a_irq),   0);
        check("rst_cnt",   32'(a_cnt),   0);
        check("rst_we",    32'(a_we),    0);
        check("rst_clr",   32'(a_clr),   0);
        check("rst_ce",    32'(a_ce),    0);
        check("rst_b_cnt", 32'(b_cnt),   0);

        // Full load with valid always high, then full -> done
        stream_a(0, SIZE_A, words);
        a_valid = 1'b1;
        a_full  = 1'b1;
        @(negedge clk);
        check("wait_ready", 32'(a_ready), 0);
        check("wait_busy",  32'(a_busy),  1);
        check("wait_done",  32'(a_done),  0);
        @(negedge clk);
        check("done_level", 32'(a_done), 1);
        check("done_irq",   32'(a_irq),  1);
        check("done_busy",  32'(a_busy), 0);
        @(posedge clk); #1;
        a_full  = 1'b0;
        a_valid = 1'b0;
        @(negedge clk);
        check("done_irq_once", 32'(a_irq),  0);
        check("done_hold",     32'(a_done), 1);
        check("t1_writes",     32'(wr_cnt), SIZE_A);
        check("t1_contiguous", 32'(last_we - first_we + 1), SIZE_A);
        check("t1_latency",    32'(first_we - start_cyc), 2);
        check("t1_words",      32'(words), SIZE_A / 4);
        check("t1_sb_empty",   32'(sb_q.size()), 0);
        check("t1_irq_cnt",    32'(irq_cnt), 1);
        for (int i = 0; i < 4; i++)
            for (int l = 0; l < 4; l++)
                check("lane_order", 32'(log_a[4*i+l]), 32'(tab_a[i].e[l]));
        check("cnt_after_word0", 32'(cnt_log[4]), 4);

        // Random valid gaps, then no full -> err after the wait window
        stream_a(30, SIZE_A, words);
        a_valid = 1'b0;
        check("t3_words",    32'(words), SIZE_A / 4);
        check("t3_writes",   32'(wr_cnt), SIZE_A);
        check("t3_cnt",      32'(a_cnt), SIZE_A);
        check("t3_sb_empty", 32'(sb_q.size()), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("wait_no_err", 32'(a_err), 0);
        end
        @(negedge clk);
        check("timeout_err", 32'(a_err), 1);
        check("timeout_irq", 32'(a_irq), 1);
        @(posedge clk); #1;
        check("t3_irq_cnt", 32'(irq_cnt), 2);

        // Early full at o_cnt=100 -> err, write suppressed
        stream_a(0, 100, words);
        a_full = 1'b1;
        @(negedge clk);
        check("ovf_we_blocked", 32'(a_we),    0);
        check("ovf_ready",      32'(a_ready), 0);
        @(negedge clk);
        check("ovf_err", 32'(a_err),  1);
        check("ovf_irq", 32'(a_irq),  1);
        check("ovf_busy", 32'(a_busy), 0);
        @(posedge clk); #1;
        a_full  = 1'b0;
        a_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("ovf_writes",  32'(wr_cnt),  100);
        check("ovf_irq_cnt", 32'(irq_cnt), 3);

        // Abort at o_cnt=1000, then restart
        stream_a(0, 1000, words);
        a_abort = 1'b1;
        @(negedge clk);
        check("abort_we",  32'(a_we),  0);
        check("abort_clr", 32'(a_clr), 0);
        @(posedge clk); #1;
        a_abort = 1'b0;
        a_valid = 1'b1;
        @(negedge clk);
        check("idle_busy",  32'(a_busy),  0);
        check("idle_ready", 32'(a_ready), 0);
        check("idle_we",    32'(a_we),    0);
        check("idle_ce",    32'(a_ce),    0);
        check("abort_cnt_held", 32'(a_cnt), 1000);
        check("abort_no_irq",   32'(a_irq), 0);
        @(posedge clk); #1;
        a_valid = 1'b0;
        irq_base = irq_cnt;
        stream_a(0, 8, words);
        check("restart_writes", 32'(wr_cnt), 8);
        check("restart_busy",   32'(a_busy), 1);
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        a_valid = 1'b0;
        @(negedge clk);
        check("abort2_idle", 32'(a_busy), 0);
        check("abort_irq_cnt", 32'(irq_cnt), 32'(irq_base));

        // SIZE=6 loader: two words accepted, six writes, third word refused
        @(posedge clk); #1;
        b_start = 1'b1;
        b_valid = 1'b1;
        b_word  = tab_b[0].word;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_word  = tab_b[i].word;
            b_valid = 1'b1;
            got     = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (b_valid && b_ready) got = 1'b1;
                @(posedge clk); #1;
                if (got) break;
            end
            check("b_accept", 32'(got), 32'(tab_b[i].acc));
        end
        b_valid = 1'b0;
        @(negedge clk);
        check("b_writes", 32'(b_wr),  SIZE_B);
        check("b_cnt",    32'(b_cnt), SIZE_B);
        check("b_err",    32'(b_err), 1);
        pos = 0;
        for (int i = 0; i < 3; i++) begin
            for (int l = 0; l < tab_b[i].nwr; l++) begin
                check("b_byte", 32'(b_log[pos]), 32'(tab_b[i].e[l]));
                pos++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
